// File: rtl/shift_fifo_pkg.sv
// Shared definitions for shift_fifo: the exit-shift operation encoding and its decode helper.
package shift_fifo_pkg;

    localparam int unsigned OpW = 2;

    typedef enum logic [OpW-1:0] {
        OP_PASS = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ASR  = 2'b11
    } shift_op_e;

    function automatic shift_op_e decode_op(input logic [OpW-1:0] raw);
        return shift_op_e'(raw);
    endfunction

endpackage

// File: rtl/shift_fifo_shift.sv
// Combinational exit shifter: pass, logical left, logical right or arithmetic right by amt_i.
module shift_unit
    import shift_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  shift_op_e        op_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (op_i)
            OP_SHL:  data_o = data_i << amt_i;
            OP_SHR:  data_o = data_i >> amt_i;
            OP_ASR:  data_o = $signed(data_i) >>> amt_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_fifo.sv
// Elastic FIFO whose registered output stage shifts each word as it leaves storage.
module shift_fifo
    import shift_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [OpW-1:0]   wr_op_i,
    input  logic [SHW-1:0]   wr_amt_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        shift_op_e        op;
        logic [SHW-1:0]   amt;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             overflow_q, overflow_d;

    logic             wr_fire;
    logic             load_fire;
    entry_t           head;
    logic [WIDTH-1:0] head_shifted;

    // Readiness comes only from the registered count, never from rd_ready_i.
    assign wr_ready_o = (count_q != CW'(DEPTH));
    assign wr_fire    = !flush_i && wr_valid_i && wr_ready_o;
    assign load_fire  = !flush_i && (count_q != '0) && (!rd_valid_q || rd_ready_i);

    assign head = mem_q[rd_ptr_q];

    shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .op_i   (head.op),
        .amt_i  (head.amt),
        .data_i (head.data),
        .data_o (head_shifted)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            // rd_data deliberately keeps its last value across a flush.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (load_fire) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = head_shifted;
                rd_valid_d = 1'b1;
            end else if (rd_valid_q && rd_ready_i) begin
                rd_valid_d = 1'b0;
            end
            unique case ({wr_fire, load_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_valid_i && !wr_ready_o) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= '{op: decode_op(wr_op_i), amt: wr_amt_i, data: wr_data_i};
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_shift_fifo.sv
// Randomised scoreboard bench for shift_fifo against a queue-based reference model.
module tb_shift_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int SHW   = 3;
    localparam int CW    = 6;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             wr_valid_i = 1'b0;
    logic             wr_ready_o;
    logic [WIDTH-1:0] wr_data_i = '0;
    logic [1:0]       wr_op_i = '0;
    logic [SHW-1:0]   wr_amt_i = '0;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [WIDTH-1:0] rd_data_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;

    always #5 clk_i = ~clk_i;

    shift_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_data_i  (wr_data_i),
        .wr_op_i    (wr_op_i),
        .wr_amt_i   (wr_amt_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Reference state: exp_q holds every accepted word not yet consumed, oldest first.
    logic [WIDTH-1:0] exp_q[$];
    int               sto_cnt     = 0;
    bit               out_valid_m = 1'b0;
    bit               overflow_m  = 1'b0;
    logic [WIDTH-1:0] rd_hold_m   = '0;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op, input int amt,
                                                   input logic [WIDTH-1:0] d);
        int v;
        int s;
        s = d[WIDTH-1] ? int'(d) - (1 << WIDTH) : int'(d);
        case (op)
            2'b01:   v = int'(d) * (1 << amt);
            2'b10:   v = int'(d) / (1 << amt);
            2'b11:   v = s >>> amt;
            default: v = int'(d);
        endcase
        return v[WIDTH-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances one clock at a time from the specification's transfer rules.
    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                exp_q.delete();
                sto_cnt     = 0;
                out_valid_m = 1'b0;
                overflow_m  = 1'b0;
                rd_hold_m   = '0;
            end else if (flush_i) begin
                exp_q.delete();
                sto_cnt     = 0;
                out_valid_m = 1'b0;
                overflow_m  = 1'b0;
            end else begin
                bit acc;
                bit ld;
                acc = wr_valid_i && (sto_cnt != DEPTH);
                ld  = (sto_cnt != 0) && (!out_valid_m || rd_ready_i);
                if (wr_valid_i && !acc) overflow_m = 1'b1;
                if (ld) begin
                    rd_hold_m   = exp_q[0];
                    out_valid_m = 1'b1;
                end else if (rd_ready_i) begin
                    out_valid_m = 1'b0;
                end
                sto_cnt = sto_cnt + int'(acc) - int'(ld);
                if (acc) exp_q.push_back(ref_shift(wr_op_i, int'(wr_amt_i), wr_data_i));
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on every DUT handshake.
    initial begin
        forever begin
            @(negedge clk_i);
            if (checking) begin
                check("rd_valid", 32'(rd_valid_o), 32'(out_valid_m));
                check("wr_ready", 32'(wr_ready_o), 32'(sto_cnt != DEPTH));
                check("count", 32'(count_o), 32'(sto_cnt));
                check("overflow", 32'(overflow_o), 32'(overflow_m));
                check("rd_data", 32'(rd_data_o), 32'(rd_hold_m));
                if (rst_ni && !flush_i && rd_valid_o && rd_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop: got %0h expected no output (scoreboard empty)",
                                 rd_data_o);
                    end else begin
                        logic [WIDTH-1:0] e;
                        e = exp_q.pop_front();
                        check("pop_order", 32'(rd_data_o), 32'(e));
                    end
                end
            end
        end
    end

    task automatic drive(input logic wv, input logic [WIDTH-1:0] d, input logic [1:0] op,
                         input logic [SHW-1:0] amt, input logic rr, input logic fl);
        wr_valid_i = wv;
        wr_data_i  = d;
        wr_op_i    = op;
        wr_amt_i   = amt;
        rd_ready_i = rr;
        flush_i    = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'b00, '0, rr, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        checking = 1'b1;
        idle(10, 1'b0);

        // Same word through each shift mode, consumed as soon as it appears.
        for (int op = 3; op >= 1; op--) begin
            drive(1'b1, 8'h81, 2'(op), 3'd2, 1'b1, 1'b0);
            idle(3, 1'b1);
        end

        // Fill beyond capacity with the consumer stalled, then drain in order.
        for (int i = 0; i < 40; i++) drive(1'b1, 8'(i), 2'b00, '0, 1'b0, 1'b0);
        idle(40, 1'b1);

        // Hold count at 5 with simultaneous write and read, then stall the consumer.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h40 + i), 2'($urandom_range(0, 3)),
                                          3'($urandom_range(0, 7)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 2'($urandom_range(0, 3)),
                                           3'($urandom_range(0, 7)), 1'b1, 1'b0);
        idle(4, 1'b0);
        idle(10, 1'b1);

        // Asynchronous reset in the middle of a burst at count 7.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'hA0 + i), 2'b11, 3'd1, 1'b0, 1'b0);
        wr_valid_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        idle(3, 1'b0);

        // Overfill, then flush; rd_data must survive the flush.
        for (int i = 0; i < 36; i++) drive(1'b1, 8'(8'hC0 + i), 2'b10, 3'd3, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 2'b00, '0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 59) == 0));
        end
        idle(40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_fifo.md
# shift_fifo

Parametrised synchronous FIFO with a registered output stage that applies a per-entry shift (logical left, logical right or arithmetic right) as each word leaves storage. It generalises the fixed 8-bit × 32-entry register array and the free-standing shift expressions into one reusable buffering block with valid/ready handshakes on both sides. It sits between any producer and consumer in the same clock domain that needs elastic buffering plus lane alignment or sign-extending scaling of data in flight.

## Interface
- WIDTH, 8, data width in bits (≥2)
- DEPTH, 32, storage entries (power of two, ≥2)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- CW, $clog2(DEPTH+1), count width (derived)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of storage and output stage
- wr_valid  in  1  producer offers a word
- wr_ready  out  1  storage can accept; equals (count != DEPTH)
- wr_data  in  WIDTH  word to store
- wr_op  in  2  shift applied on exit: 00 pass, 01 <<, 10 >>, 11 >>>
- wr_amt  in  SHW  shift distance, 0..WIDTH-1
- rd_valid  out  1  output register holds a word
- rd_ready  in  1  consumer takes the word
- rd_data  out  WIDTH  shifted word
- count  out  CW  words in storage (excludes output register)
- overflow  out  1  sticky: wr_valid seen while wr_ready low

## Operation
- Storage: DEPTH entries of {op, amt, data}; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- Write fires when wr_valid && wr_ready: entry written at wr_ptr, wr_ptr+1.
- Output load fires when count != 0 && (!rd_valid || rd_ready): rd_data <= shift(mem[rd_ptr]), rd_valid <= 1, rd_ptr+1.
- Read completes when rd_valid && rd_ready; if no load fires in the same cycle, rd_valid <= 0.
- count: +1 on write only, -1 on load only, unchanged when both fire (including at count == DEPTH: wr_ready is low, so no write; at count == 0 no load).
- Shift: 01 = data << amt, 10 = data >> amt (zero fill), 11 = data >>> amt with data treated as signed (MSB fill). Result truncated to WIDTH.
- Bypass is not provided: a word written into empty storage always passes through memory.
- overflow set on wr_valid && !wr_ready; cleared only by reset or flush. Dropped word is not stored.
- flush: pointers, count, rd_valid, overflow cleared at the next edge; wr/load in the same cycle are ignored. rd_data retains its value.

## Timing
- Reset values: wr_ready 1, rd_valid 0, rd_data 0, count 0, overflow 0, pointers 0.
- Reset asserts asynchronously mid-transfer; all in-flight words are discarded.
- Latency: write accepted at edge N, word in output register and rd_valid high after edge N+1 (two cycles wr_valid-to-rd_valid from an empty block).
- Throughput: one write and one read per cycle sustained; with rd_ready held high, the output register reloads every cycle while count != 0.
- wr_ready depends only on registered count (no combinational path from rd_ready).
- rd_valid/rd_data stable while rd_valid && !rd_ready.
- Full-buffer capacity: DEPTH words in storage + 1 in output register.

## Structure
- Package shift_fifo_pkg: op encoding constants (OP_PASS, OP_SHL, OP_SHR, OP_ASR), entry typedef {op, amt, data}, shift function.
- One sub-module: shift_unit (combinational, WIDTH parameter, op/amt/data in, result out), instantiated on the memory read path.
- Memory as an unpacked array of entry typedef; no vendor RAM.

## Test plan
- Reset then idle: wr_ready 1, rd_valid 0, count 0, rd_data 0 for 10 cycles.
- Write 0x81 op 11 amt 2, rd_ready 1: rd_valid two edges later with rd_data 0xE0; same word with op 10 gives 0x20, op 01 gives 0x04.
- Fill 32 words with rd_ready 0: 33 accepted total (32 + output reg), count 32, wr_ready 0; extra wr_valid sets overflow; drain returns words in order 0..32, pointers wrap.
- Simultaneous write and read at count 5 for 20 cycles: count stays 5, data order preserved.
- Stall: rd_ready low 4 cycles with rd_valid high: rd_data unchanged each cycle.
- Assert rst_n low mid-burst (count 7), then flush in a separate run: both return all outputs to reset values; flush leaves rd_data unchanged.
